// File: rtl/entropy_conditioner.sv
// entropy_conditioner: synchronizes a raw ring-oscillator bit, debiases it with a von Neumann pair
// extractor and counts emitted bits; the repetition-count health test is built with ENTROPY_HEALTH_TEST_EN.
module entropy_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int REP_LIMIT   = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 raw_in,
    output logic                 random,
    output logic                 random_valid,
    output logic                 health_fail,
    output logic [CNT_WIDTH-1:0] bits_out
);
    localparam int WW = $clog2(SYNC_STAGES + 1);
    typedef enum logic {FIRST, SECOND} state_t;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [WW-1:0]          warm_q, warm_d;
    logic                   a_q, a_d;
    logic                   random_q, random_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   s, smp, gate;
    assign s   = sync_q[SYNC_STAGES-1];
    assign smp = warm_q == WW'(SYNC_STAGES);
`ifdef ENTROPY_HEALTH_TEST_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    logic [RW-1:0] run_q, run_d;
    logic          prev_q, prev_d, fail_q, fail_d, trip;
    always_comb begin
        run_d  = run_q;
        prev_d = prev_q;
        if (smp) begin
            run_d  = (run_q == '0 || s != prev_q) ? RW'(1) :
                     (run_q == RW'(REP_LIMIT)) ? run_q : run_q + 1'b1;
            prev_d = s;
        end
        trip   = smp && run_d == RW'(REP_LIMIT);
        fail_d = fail_q | trip;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            prev_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            prev_q <= prev_d;
            fail_q <= fail_d;
        end
    end
    // a tripping sample also suppresses the bit it would complete
    assign gate        = fail_q | trip;
    assign health_fail = fail_q;
`else
    assign gate        = 1'b0;
    assign health_fail = 1'b0;
`endif
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
        warm_d   = smp ? warm_q : warm_q + 1'b1;
        state_d  = state_q;
        a_d      = a_q;
        valid_d  = 1'b0;
        random_d = 1'b0;
        cnt_d    = cnt_q;
        if (smp) begin
            if (state_q == FIRST) begin
                a_d     = s;
                state_d = SECOND;
            end else begin
                state_d = FIRST;
                if (a_q != s && !gate) begin
                    valid_d  = 1'b1;
                    random_d = a_q;
                    cnt_d    = &cnt_q ? cnt_q : cnt_q + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            warm_q   <= '0;
            state_q  <= FIRST;
            a_q      <= 1'b0;
            random_q <= 1'b0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            warm_q   <= warm_d;
            state_q  <= state_d;
            a_q      <= a_d;
            random_q <= random_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end
    assign random       = random_q;
    assign random_valid = valid_q;
    assign bits_out     = cnt_q;
endmodule

// File: tb/tb_entropy_conditioner.sv
// tb_entropy_conditioner: directed stimulus with a pulse scoreboard; a second instance
// with CNT_WIDTH=4 shares the stimulus to exercise counter saturation.
module tb_entropy_conditioner;
    logic clk = 1'b0, rst = 1'b1, raw_in = 1'b0;
    logic random, random_valid, health_fail;
    logic [15:0] bits_out;
    logic random4, random_valid4, health_fail4;
    logic [3:0] bits_out4;
    int checks = 0, errors = 0, cyc = 0;
    typedef struct {int c; int b; int n; int n4;} exp_t;
    exp_t q[$];
`ifdef ENTROPY_HEALTH_TEST_EN
    localparam int HE = 1;
`else
    localparam int HE = 0;
`endif
    localparam int HOLD = 200;

    always #5 clk = ~clk;

    entropy_conditioner dut (.clk(clk), .rst(rst), .raw_in(raw_in), .random(random),
        .random_valid(random_valid), .health_fail(health_fail), .bits_out(bits_out));
    entropy_conditioner #(.CNT_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .raw_in(raw_in), .random(random4),
        .random_valid(random_valid4), .health_fail(health_fail4), .bits_out(bits_out4));

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input int b, input int n);
        q.push_back('{c, b, n, (n > 15) ? 15 : n});
    endtask

    task automatic step(input logic b);
        raw_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input logic b);
        repeat (4) step(b);
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", random_valid, 0);
        chk("rst_random", random, 0);
        chk("rst_health", health_fail, 0);
        chk("rst_bits", bits_out, 0);
        chk("rst_bits4", bits_out4, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("valid4_match", random_valid4, random_valid);
        chk("random4_match", random4, random);
        if (random_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: random_valid=1 random=%0d, required no pulse", cyc, random);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.c);
                chk("pulse_bit", random, e.b);
                chk("pulse_count", bits_out, e.n);
                chk("pulse_count4", bits_out4, e.n4);
            end
        end else begin
            chk("random_idle", random, 0);
        end
    end

    initial begin
        // alternating 0,1: pair (0,1) ends at odd sample 2k+1, pulse at cycle 2k+4
        do_reset();
        for (int k = 0; k < 20; k++) push(2 * k + 4, 0, k + 1);
        for (int i = 0; i < 40; i++) begin
            step(i[0]);
            if (i == 18) begin
                chk("alt_bits_after8", bits_out, 8);
                chk("alt_health", health_fail, 0);
            end
        end
        flush(1'b1);
        chk("alt_bits_final", bits_out, 20);
        chk("sat_bits4", bits_out4, 15);

        // pair decoding 10 11 00 10
        do_reset();
        push(4, 1, 1);
        push(10, 1, 2);
        step(1); step(0); step(1); step(1);
        step(0); step(0); step(1); step(0);
        flush(1'b0);
        chk("pair_bits", bits_out, 2);

        // reset between the two halves of a 1,0 pair
        do_reset();
        step(1); step(0); step(0);
        do_reset();
        push(4, 0, 1);
        push(6, 1, 2);
        step(0); step(1); step(1); step(0);
        flush(1'b0);
        chk("rmp_bits", bits_out, 2);

        // long run of ones, then alternating
        do_reset();
        for (int i = 1; i <= HOLD; i++) begin
            step(1);
            if (i == 33) chk("health_pre", health_fail, 0);
            if (i == 34) chk("health_trip", health_fail, HE);
        end
        if (HE == 0) for (int k = 0; k < 4; k++) push(HOLD + 4 + 2 * k, 0, k + 1);
        for (int i = 0; i < 8; i++) step(i[0]);
        flush(1'b1);
        chk("health_sticky", health_fail, HE);
        chk("health4", health_fail4, HE);
        chk("health_bits", bits_out, HE ? 0 : 4);
        do_reset();
        chk("health_cleared", health_fail, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/entropy_conditioner.md
# entropy_conditioner

Upstream stage of the LFSR whitener: takes the raw, asynchronous bit from a ring-oscillator sampler, synchronizes it, removes bias with a von Neumann pair extractor and runs a repetition-count health test. It emits a one-cycle strobed bit on `random`, which is 0 whenever no bit is emitted, so it wires directly to the LFSR's `random` input; XOR with 0 leaves the register's own feedback unchanged. It also keeps a saturating count of emitted bits and a sticky failure flag.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth, at least 2.
- `REP_LIMIT`, default 32: run length of identical samples that trips the health test, at least 2.
- `CNT_WIDTH`, default 16: width of `bits_out`.
- `clk`  input  1  single clock.
- `rst`  input  1  reset, synchronous and active-high.
- `raw_in`  input  1  raw ring-oscillator bit, asynchronous to `clk`.
- `random`  output  1  debiased bit; 0 when `random_valid` is 0.
- `random_valid`  output  1  one-cycle strobe marking `random` as a fresh bit.
- `health_fail`  output  1  sticky health-test failure.
- `bits_out`  output  CNT_WIDTH  number of emitted bits, saturating at all-ones.

## Operation
- **Synchronizer:** `SYNC_STAGES` flops, all reset to 0. The last stage is sample `s`.
- **Warm-up:** for `SYNC_STAGES` cycles after reset, samples are ignored by both the pair FSM and the health test.
- **Pair FSM:** two states.
  - FIRST (reset state): latch `s` into `a`, go to SECOND.
  - SECOND: if `a != s`, emit bit `a` (01 gives 0, 10 gives 1); if equal, discard. Always return to FIRST.
  - Pairs are aligned to the first post-warm-up sample.
- **Output:** `random_valid` and `random` are registered. When no bit is emitted, both are 0 the next cycle.
- **Bit counter:** `bits_out` increments on every emitted bit and holds at 2^CNT_WIDTH−1.
- **Health test:** `run_len` is ceil(log2(REP_LIMIT+1)) bits and resets to 0.
  - Each valid sample: if `run_len` is 0 or `s != prev`, set `run_len` to 1; otherwise increment, saturating at `REP_LIMIT`.
  - `prev` takes the value of `s`.
  - When `run_len` reaches `REP_LIMIT`, `health_fail` is set. Only `rst` clears it.
- **Gating:** while `health_fail` is 1, no bits are emitted and `bits_out` freezes. The FSM keeps toggling.
- **Simultaneous events:** if the sample that completes a differing pair also trips the health test, that bit is suppressed.
- **Reset mid-operation:** a pending first-of-pair is dropped and warm-up restarts. All outputs read 0 in the cycle after the reset edge.

## Timing
- **Reset values:** `random`=0, `random_valid`=0, `health_fail`=0, `bits_out`=0.
- **Sample timing:** `raw_in` appears at `s` `SYNC_STAGES` edges after it is sampled. Sample n is the value of `s` during cycle n.
- **Emit latency:** a pair whose second sample is n gives `random_valid`=1 during cycle n+1, for exactly one cycle.
- **Throughput:** at most one bit per 2 cycles; `random_valid` never asserts in consecutive cycles.
- **Health latency:** the sample making `run_len` equal `REP_LIMIT` at cycle n gives `health_fail`=1 from cycle n+1.
- **Counter latency:** `bits_out` updates in the same cycle `random_valid` is high.

## Configuration
- **`ENTROPY_HEALTH_TEST_EN` defined:** `run_len`, `prev`, `health_fail` and output gating are built as described.
- **Not defined:**
  - No run-length logic is built.
  - `health_fail` is tied to 0.
  - Emission is never gated.
  - All other behaviour is identical.

## Test plan
All scenarios use defaults (`SYNC_STAGES`=2, `REP_LIMIT`=32) unless noted.
- **Alternating pattern:** `rst` for 1 cycle, then `raw_in` alternates 0,1 each cycle, with sample 0 equal to 0 -> `random_valid` pulses every 2nd cycle with `random`=0. After 8 pulses, `bits_out`=8 and `health_fail`=0.
- **Pair decoding:** post-warm-up samples 1,0, 1,1, 0,0, 1,0 -> exactly two pulses, both `random`=1, one cycle after samples 1 and 7. `bits_out`=2.
- **Health trip:** `raw_in` held 1 -> no pulses. `health_fail` rises the cycle after the 32nd post-warm-up sample. Applying a 0,1 pattern afterwards gives no pulses and `bits_out` frozen.
- **Reset mid-pair:** assert `rst` between the first and second sample of a differing pair -> no pulse for that pair and all outputs 0. Pair alignment restarts `SYNC_STAGES` cycles after `rst` deasserts.
- **Counter saturation:** `CNT_WIDTH`=4 with an alternating pattern for 40 cycles -> `bits_out` stops at 15, while pulses continue.
- **Macro off:** compile without `ENTROPY_HEALTH_TEST_EN` and hold `raw_in` at 1 for 200 samples, then alternate -> `health_fail` stays 0 and pulses resume normally.
